lfsr_gen: RTL
=============

// Module: lfsr_gen
// PURPOSE
//  Parametrised LFSR pseudo-random sequence generator for DE1 lab designs; next generation of the fixed
//  6-bit Fibonacci LFSR. Adds configurable width/taps, Fibonacci or Galois form, step enable, seed load,
//  all-zero lockup protection and on-line period measurement. Top level drives clk from KEY[0] (posedge),
//  rst_n from KEY[3], en/load from SW; state/flags go to LEDR/HEX.
// PARAMETERS
//  WIDTH   6             state width, legal 3..32
//  TAPS    6'b110000     Fibonacci feedback mask (bit i set => state[i] XORed into feedback); bit WIDTH-1 must be set
//  SEED    6'b000001     reset/recovery state; nonzero (zero is illegal, elaboration error)
//  GALOIS  0             0 = Fibonacci form, 1 = Galois form of the same polynomial
// PORTS
//  clk          in   1      clock, rising edge
//  rst_n        in   1      asynchronous active-low reset
//  en           in   1      advance one step this cycle
//  load         in   1      load load_val this cycle (priority over en)
//  load_val     in   WIDTH  value to load
//  state        out  WIDTH  current LFSR state (registered)
//  bit_out      out  1      serial output = state[WIDTH-1]
//  wrap         out  1      1-cycle pulse: state just returned to reference seed
//  period       out  WIDTH  steps of last completed cycle
//  period_valid out  1      period holds a valid measurement
//  lockup       out  1      sticky: last load requested all-zero value
// BEHAVIOUR
//  Reset (async, rst_n=0): state=SEED, ref_seed=SEED, step_cnt=0, wrap=0, period=0, period_valid=0, lockup=0.
//  Step (en=1, load=0), next state visible the cycle after the edge (latency 1):
//   Fibonacci: state <= {state[WIDTH-2:0], ^(state & TAPS)}   (defaults reproduce s1<=s5^s6 shift chain)
//   Galois:    state <= (state<<1)[WIDTH-1:0] ^ ({WIDTH{state[WIDTH-1]}} & GMASK),
//              GMASK = ((TAPS<<1) | 1) truncated to WIDTH (default 6'b100001)
//  Hold (en=0, load=0): all registers hold; wrap=0.
//  Load (load=1, en ignored): if load_val!=0 -> state<=load_val, ref_seed<=load_val, lockup<=0;
//   if load_val==0 -> state<=SEED, ref_seed<=SEED, lockup<=1 (all-zero never enters the register).
//   Load clears step_cnt and period_valid, period<=0, wrap=0.
//  Period measurement: each step increments step_cnt; if the next state == ref_seed then wrap=1 in the
//   cycle the new state appears, period<=step_cnt+1, period_valid<=1, step_cnt<=0.
//   step_cnt saturates at 2^WIDTH-1 (cannot overflow; any tap set with bit WIDTH-1 is invertible, so it always returns).
//  wrap is registered, one cycle wide; consecutive wraps only possible for period 1 (not reachable with legal TAPS/SEED).
//  Mid-operation reset: immediate return to reset values regardless of en/load.
//  No combinational path from inputs to outputs; bit_out derives from registered state.
// TESTING
//  1 reset defaults: rst_n=0 -> state=6'b000001, period_valid=0, lockup=0; release, en=0 x5 -> state unchanged.
//  2 Fibonacci default: en=1 from seed -> states 02,04,08,10,21,...; 63rd step state=01, wrap=1 that cycle, period=63, period_valid=1.
//  3 Galois (GALOIS=1): en=1 from 01 -> 02,04,08,10,20,21,...; period=63 after 63 steps, sequence matches golden model.
//  4 load: after 10 steps load=1,en=1,load_val=6'h2A -> state=2A next cycle, period_valid=0; 63 steps later wrap=1 at 2A.
//  5 lockup: load_val=0 -> state=01, lockup=1; later load_val=05 -> lockup=0.
//  6 mid-run reset & widths: assert rst_n=0 at step 30 -> state=SEED immediately; WIDTH=16, TAPS=16'hB400 -> period=65535.

Source files
------------

// File: rtl/lfsr_gen.sv
// lfsr_gen: parametrised Fibonacci/Galois LFSR with seed load, lockup guard and period measurement
module lfsr_gen #(
    parameter int               WIDTH  = 6,
    parameter logic [WIDTH-1:0] TAPS   = 6'b110000,
    parameter logic [WIDTH-1:0] SEED   = 6'b000001,
    parameter bit               GALOIS = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] state,
    output logic             bit_out,
    output logic             wrap,
    output logic [WIDTH-1:0] period,
    output logic             period_valid,
    output logic             lockup
);
    localparam logic [WIDTH-1:0] GMASK   = {TAPS[WIDTH-2:0], 1'b1};
    localparam logic [WIDTH-1:0] CNT_MAX = '1;
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

    if (WIDTH < 3 || WIDTH > 32) begin : g_bad_width
        $error("lfsr_gen: WIDTH must be in 3..32");
    end
    if (SEED == '0) begin : g_bad_seed
        $error("lfsr_gen: SEED must be nonzero");
    end
    if (TAPS[WIDTH-1] != 1'b1) begin : g_bad_taps
        $error("lfsr_gen: TAPS bit WIDTH-1 must be set");
    end

    logic [WIDTH-1:0] state_q, state_d, ref_q, ref_d, cnt_q, cnt_d, period_q, period_d, nxt;
    logic             wrap_q, wrap_d, pv_q, pv_d, lockup_q, lockup_d;

    // next LFSR state plus load / step / period bookkeeping; an all-zero load falls back to SEED
    always_comb begin
        nxt = GALOIS ? ({state_q[WIDTH-2:0], 1'b0} ^ ({WIDTH{state_q[WIDTH-1]}} & GMASK))
                     : {state_q[WIDTH-2:0], ^(state_q & TAPS)};
        state_d  = state_q;
        ref_d    = ref_q;
        cnt_d    = cnt_q;
        period_d = period_q;
        pv_d     = pv_q;
        lockup_d = lockup_q;
        wrap_d   = 1'b0;
        if (load) begin
            state_d  = (load_val != '0) ? load_val : SEED;
            ref_d    = (load_val != '0) ? load_val : SEED;
            lockup_d = (load_val == '0);
            cnt_d    = '0;
            period_d = '0;
            pv_d     = 1'b0;
        end else if (en) begin
            state_d = nxt;
            if (nxt == ref_q) begin
                wrap_d   = 1'b1;
                period_d = cnt_q + ONE;
                pv_d     = 1'b1;
                cnt_d    = '0;
            end else begin
                cnt_d = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + ONE;
            end
        end
    end

    // state registers with asynchronous reset to the seed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= SEED;
            ref_q    <= SEED;
            cnt_q    <= '0;
            period_q <= '0;
            wrap_q   <= 1'b0;
            pv_q     <= 1'b0;
            lockup_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            ref_q    <= ref_d;
            cnt_q    <= cnt_d;
            period_q <= period_d;
            wrap_q   <= wrap_d;
            pv_q     <= pv_d;
            lockup_q <= lockup_d;
        end
    end

    assign state        = state_q;
    assign bit_out      = state_q[WIDTH-1];
    assign wrap         = wrap_q;
    assign period       = period_q;
    assign period_valid = pv_q;
    assign lockup       = lockup_q;
endmodule
